// File: rtl/corelet_ctrl.sv
// corelet_ctrl: single-tile sequencer for the corelet instruction bus.
// Runs weight fetch, weight load, settle, activation fetch, execute and
// OFIFO drain. The instruction word is fully registered: handshake inputs
// sampled on a clock edge shape the word driven during the following cycle.
module corelet_ctrl #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int l0_depth = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] w_base,
  input  logic [10:0] x_base,
  input  logic [10:0] p_base,
  input  logic [10:0] n_act,
  input  logic        l0_o_full,
  input  logic        l0_o_ready,
  input  logic        ofifo_o_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
  localparam logic [10:0] COL_W     = 11'(col);
  localparam logic [10:0] SETTLE_W  = 11'(row + col);
  localparam logic [10:0] DEPTH_W   = 11'(l0_depth);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WFILL  = 3'd1;
  localparam logic [2:0] S_WLOAD  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_XFILL  = 3'd4;
  localparam logic [2:0] S_EXEC   = 3'd5;
  localparam logic [2:0] S_DRAIN  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [10:0] cnt_q, cnt_d;     // reads issued / pops / settle cycles
  logic [10:0] wcnt_q, wcnt_d;   // pmem writes issued
  logic [33:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic [10:0] wb_q, wb_d, xb_q, xb_d, pb_q, pb_d, na_q, na_d;

  logic [10:0] cnt_b, wcnt_b, lim, base;
  logic        act;

  // Next state is decided first; the word for the coming cycle is then
  // built from that next state so each phase's first action lands in its
  // first cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    inst_d  = IDLE_WORD;
    err_d   = 1'b0;
    wb_d    = wb_q;
    xb_d    = xb_q;
    pb_d    = pb_q;
    na_d    = na_q;
    lim     = '0;
    base    = '0;
    act     = 1'b0;

    case (state_q)
      S_IDLE: if (start) begin
        if (n_act == '0 || n_act > DEPTH_W) begin
          err_d = 1'b1;
        end else begin
          state_d = S_WFILL;
          wb_d    = w_base;
          xb_d    = x_base;
          pb_d    = p_base;
          na_d    = n_act;
        end
      end
      // A fill ends once all reads are out and the current cycle carries
      // no read, i.e. the final L0 write is the one being driven now.
      S_WFILL:  if (cnt_q == COL_W && inst_q[19]) state_d = S_WLOAD;
      S_WLOAD:  if (cnt_q == COL_W) state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == SETTLE_W) state_d = S_XFILL;
      S_XFILL:  if (cnt_q == na_q && inst_q[19]) state_d = S_EXEC;
      S_EXEC:   if (cnt_q == na_q) state_d = S_DRAIN;
      S_DRAIN:  if (wcnt_q == na_q) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase

    cnt_b  = (state_d == state_q) ? cnt_q  : '0;
    wcnt_b = (state_d == state_q) ? wcnt_q : '0;

    case (state_d)
      S_WFILL, S_XFILL: begin
        lim       = (state_d == S_WFILL) ? COL_W : na_d;
        base      = (state_d == S_WFILL) ? wb_d : xb_d;
        act       = (cnt_b < lim) && !l0_o_full;
        inst_d[2] = !inst_q[19];
        if (act) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = base + cnt_b;
        end
        cnt_d = cnt_b + {10'd0, act};
      end
      S_WLOAD, S_EXEC: begin
        lim = (state_d == S_WLOAD) ? COL_W : na_d;
        act = (cnt_b < lim) && l0_o_ready;
        inst_d[3] = act;
        if (state_d == S_WLOAD) inst_d[0] = act;
        else                    inst_d[1] = act;
        cnt_d = cnt_b + {10'd0, act};
      end
      S_SETTLE: cnt_d = cnt_b + 11'd1;
      S_DRAIN: begin
        act       = (cnt_b < na_d) && ofifo_o_valid;
        inst_d[6] = act;
        cnt_d     = cnt_b + {10'd0, act};
        wcnt_d    = wcnt_b;
        if (inst_q[6]) begin
          inst_d[32]    = 1'b0;
          inst_d[31]    = 1'b0;
          inst_d[30:20] = pb_d + wcnt_b;
          wcnt_d        = wcnt_b + 11'd1;
        end
      end
      default: begin
        cnt_d  = '0;
        wcnt_d = '0;
      end
    endcase
  end

  // State, counters, captured tile parameters and the output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      inst_q  <= IDLE_WORD;
      err_q   <= 1'b0;
      wb_q    <= '0;
      xb_q    <= '0;
      pb_q    <= '0;
      na_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      wb_q    <= wb_d;
      xb_q    <= xb_d;
      pb_q    <= pb_d;
      na_q    <= na_d;
    end
  end

  assign inst = inst_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Testbench for corelet_ctrl. Handshake inputs are pre-generated per cycle
// (cycle 0 = the start cycle); a phase-by-phase model turns them into the
// expected instruction word for every cycle of the tile, where an input
// presented in cycle t shapes the word of cycle t+1.
module tb_corelet_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int L0D = 64;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
  localparam int TMAX = 2040;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [10:0] w_base, x_base, p_base, n_act;
  logic        l0_o_full, l0_o_ready, ofifo_o_valid;
  logic [33:0] inst;
  logic        busy, done, err;

  int compared = 0;
  int mismatched = 0;

  bit          full_a [2048];
  bit          rdy_a  [2048];
  bit          val_a  [2048];
  logic [33:0] exp_a  [2048];
  int          t_done, t_exec;

  always #5 clk = ~clk;

  corelet_ctrl #(.row(ROW), .col(COL), .l0_depth(L0D)) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .x_base(x_base), .p_base(p_base), .n_act(n_act),
    .l0_o_full(l0_o_full), .l0_o_ready(l0_o_ready), .ofifo_o_valid(ofifo_o_valid),
    .inst(inst), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // mode 0: never stall; 1: random handshakes; 2: 3-cycle L0 full during
  // weight fetch plus a bursty OFIFO at drain start.
  task automatic gen_inputs(input int mode);
    for (int i = 0; i < 2048; i++) begin
      full_a[i] = 1'b0; rdy_a[i] = 1'b1; val_a[i] = 1'b1;
      if (mode == 1) begin
        full_a[i] = ($urandom % 4) == 0;
        rdy_a[i]  = ($urandom % 3) != 0;
        val_a[i]  = ($urandom % 2) == 0;
      end else if (mode == 2) begin
        full_a[i] = (i >= 3 && i <= 5);
      end
    end
  endtask

  task automatic m_fill(input logic [10:0] base, input int n, inout int t);
    int issued = 0;
    bit rd = 1'b0;
    bit prev = 1'b0;
    logic [33:0] w;
    do begin
      w = IDLE_W;
      if (prev) w[2] = 1'b1;
      rd = (issued < n) && !full_a[t-1];
      if (rd) begin
        w[19] = 1'b0;
        w[17:7] = base + 11'(issued);
        issued++;
      end
      exp_a[t] = w;
      t++;
      prev = rd;
    end while (!(issued == n && !rd) && t < TMAX);
  endtask

  task automatic m_pop(input int n, input int bitpos, inout int t);
    int popped = 0;
    logic [33:0] w;
    while (popped < n && t < TMAX) begin
      w = IDLE_W;
      if (rdy_a[t-1]) begin
        w[3] = 1'b1;
        w[bitpos] = 1'b1;
        popped++;
      end
      exp_a[t] = w;
      t++;
    end
  endtask

  task automatic m_drain(input logic [10:0] base, input int n, inout int t);
    int reads = 0;
    int writes = 0;
    bit prev = 1'b0;
    logic [33:0] w;
    while (writes < n && t < TMAX) begin
      w = IDLE_W;
      if (prev) begin
        w[32] = 1'b0;
        w[31] = 1'b0;
        w[30:20] = base + 11'(writes);
        writes++;
      end
      prev = (reads < n) && val_a[t-1];
      if (prev) begin
        w[6] = 1'b1;
        reads++;
      end
      exp_a[t] = w;
      t++;
    end
  endtask

  task automatic build(input logic [10:0] wb, xb, pb, input int n, input int mode);
    int t = 1;
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    m_fill(wb, COL, t);
    m_pop(COL, 0, t);
    for (int i = 0; i < ROW + COL; i++) begin
      exp_a[t] = IDLE_W;
      t++;
    end
    m_fill(xb, n, t);
    t_exec = t;
    m_pop(n, 1, t);
    if (mode == 2)
      for (int i = 0; i < 7; i++) val_a[t-1+i] = pat[i];
    m_drain(pb, n, t);
    t_done = t;
    exp_a[t] = IDLE_W;
    exp_a[t+1] = IDLE_W;
  endtask

  task automatic drive(input int k);
    l0_o_full     = full_a[k];
    l0_o_ready    = rdy_a[k];
    ofifo_o_valid = val_a[k];
  endtask

  task automatic run_tile(input logic [10:0] wb, xb, pb, input int n, input int mode,
                          input bit abort_exec);
    int abort_at;
    gen_inputs(mode);
    build(wb, xb, pb, n, mode);
    abort_at = abort_exec ? t_exec + 1 : -10;
    @(posedge clk); #1;
    start = 1'b1; w_base = wb; x_base = xb; p_base = pb; n_act = 11'(n);
    drive(0);
    for (int k = 1; k <= t_done + 1; k++) begin
      @(posedge clk); #1;
      // Stray starts and parameter changes while busy must not disturb the tile.
      start  = (k <= t_done) && (k < abort_at) && (($urandom % 8) == 0);
      w_base = 11'($urandom); x_base = 11'($urandom); p_base = 11'($urandom);
      n_act  = 11'($urandom_range(0, 100));
      reset  = (k == abort_at);
      drive(k);
      @(negedge clk);
      if (k == abort_at + 1) begin
        chk("abort_inst", inst, IDLE_W);
        chk("abort_busy", {33'd0, busy}, 34'd0);
        chk("abort_done", {33'd0, done}, 34'd0);
        reset = 1'b0;
        return;
      end
      chk($sformatf("inst@%0d", k), inst, exp_a[k]);
      chk($sformatf("busy@%0d", k), {33'd0, busy}, {33'd0, (k <= t_done)});
      chk($sformatf("done@%0d", k), {33'd0, done}, {33'd0, (k == t_done)});
      chk($sformatf("err@%0d", k), {33'd0, err}, 34'd0);
    end
    start = 1'b0;
  endtask

  task automatic reject(input logic [10:0] n);
    @(posedge clk); #1;
    start = 1'b1; n_act = n;
    @(posedge clk); #1;
    start = 1'b0; n_act = 11'd4;
    @(negedge clk);
    chk("rej_err", {33'd0, err}, 34'd1);
    chk("rej_busy", {33'd0, busy}, 34'd0);
    chk("rej_inst", inst, IDLE_W);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rej_err_clear", {33'd0, err}, 34'd0);
    chk("rej_busy2", {33'd0, busy}, 34'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    w_base = '0; x_base = '0; p_base = '0; n_act = 11'd4;
    l0_o_full = 1'b0; l0_o_ready = 1'b0; ofifo_o_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      l0_o_full = 1'($urandom); l0_o_ready = 1'($urandom); ofifo_o_valid = 1'($urandom);
      @(negedge clk);
      chk("idle_inst", inst, IDLE_W);
      chk("idle_busy", {33'd0, busy}, 34'd0);
      chk("idle_done", {33'd0, done}, 34'd0);
      chk("idle_err", {33'd0, err}, 34'd0);
    end

    run_tile(11'd0, 11'd16, 11'd32, 4, 0, 1'b0);
    run_tile(11'd0, 11'd16, 11'd32, 4, 2, 1'b0);
    reject(11'd0);
    reject(11'd65);
    run_tile(11'd100, 11'd200, 11'd300, 64, 0, 1'b0);
    run_tile(11'd2044, 11'd2046, 11'd2040, 8, 1, 1'b0);
    run_tile(11'd5, 11'd7, 11'd2047, 1, 1, 1'b0);
    run_tile(11'd0, 11'd16, 11'd32, 4, 0, 1'b1);
    run_tile(11'd0, 11'd16, 11'd32, 4, 0, 1'b0);
    repeat (6)
      run_tile(11'($urandom), 11'($urandom), 11'($urandom), $urandom_range(1, L0D), 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
